// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W    = 32;
  localparam int unsigned FIFO_DEPTH     = 128;
  localparam int unsigned FIFO_AF_MARGIN = 4;
  localparam int unsigned FIFO_AE_LEVEL  = 4;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for param_fifo: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents survive reset and clear; occupancy alone decides what is valid.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// Single-clock first-word-fall-through FIFO with level, threshold flags and sticky error flags.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = FIFO_DATA_W,
  parameter int unsigned DEPTH    = FIFO_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - FIFO_AF_MARGIN,
  parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     write,
  input  logic [DATA_W-1:0]        data_write,
  input  logic                     read,
  output logic [DATA_W-1:0]        data_read,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_write,
  output logic                     err_read,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH > 4096) begin : g_bad_depth
    $error("param_fifo: DEPTH must be a power of two in 4..4096");
  end
  if (DATA_W < 1 || DATA_W > 256) begin : g_bad_width
    $error("param_fifo: DATA_W must be in 1..256");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
    $error("param_fifo: AF_LEVEL must be in 1..DEPTH-1");
  end
  if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("param_fifo: AE_LEVEL must be in 1..DEPTH-1");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_ok, wr_ok, wr_en;

  // Request/accept: a read is taken only when a word is already stored (no
  // write-to-read bypass); a write is taken when there is room or when the
  // same cycle's read frees a slot. Rejected requests are flagged, not held.
  always_comb begin
    rd_ok = read && (level_q != '0);
    wr_ok = write && ((level_q != LVL_W'(DEPTH)) || rd_ok);
  end

  assign err_write = write && !wr_ok;
  assign err_read  = read && empty;
  assign wr_en     = wr_ok && !clear;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q | err_write;
    underflow_d = underflow_q | err_read;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_write),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_read)
  );

  assign level        = level_q;
  assign full         = (level_q == LVL_W'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LVL_W'(AF_LEVEL));
  assign almost_empty = (level_q <= LVL_W'(AE_LEVEL));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
